dma_wr_sched: RTL and testbench
===============================

# dma_wr_sched

Job scheduler placed directly upstream of `dma_wr`. It accepts one large write job (base address plus length in words) and splits it into AXI-legal burst commands on the `dma_wr` configuration interface. Each command respects `MAX_BURST` and, optionally, 4 KB page boundaries. The block then waits for `dma_wr` to drain and pulses `job_done`, which gives software or the control FSM a single completion event per frame.

## Interface
- `AXI_DATA_WIDTH`, 32: data width; bytes per word `BPW = AXI_DATA_WIDTH/8`.
- `AXI_ADDR_WIDTH`, 32: address width.
- `CONFIG_LEN_WIDTH`, 9: command length width, in words.
- `JOB_LEN_WIDTH`, 20: job length width, in words.
- `MAX_BURST`, 256: maximum words per command. Must be ≤ 256 and ≤ 2^`CONFIG_LEN_WIDTH`−1.
- `DRAIN_GUARD`, 2: cycles after the last command during which `cmd_empty` is ignored.

Ports:
- `clk` in 1: clock. One clock domain only.
- `rst_n` in 1: reset, asynchronous, active-low.
- `job_valid` in 1: job request.
- `job_ready` out 1: high only in IDLE.
- `job_addr` in `AXI_ADDR_WIDTH`: job base address. The low `log2(BPW)` bits are forced to 0.
- `job_len` in `JOB_LEN_WIDTH`: job length in words.
- `job_done` out 1: one-cycle completion pulse.
- `busy` out 1: state ≠ IDLE.
- `cmd_valid` out 1: command valid. Connect to `config_valid` through `cmd_valid & cmd_ready`, because `dma_wr` pushes on valid alone.
- `cmd_ready` in 1: from `config_ready`.
- `cmd_addr` out `AXI_ADDR_WIDTH`: command byte address.
- `cmd_len` out `CONFIG_LEN_WIDTH`: command length in words, always ≥ 1.
- `cmd_empty` in 1: from `config_empty`.
- `chunk_cnt` out 16: commands issued for the current job. Clears on job accept and saturates at 0xFFFF.

## Operation
States are IDLE, CALC, ISSUE and DRAIN.

- **IDLE:** on `job_valid & job_ready`, load `addr_r` and `rem_r ← job_len`, clear `chunk_cnt`, go to CALC.
- **CALC** (one cycle):
  - Register `chunk = min(rem_r, MAX_BURST, bnd)`, where `bnd = (4096 − addr_r[11:0]) >> log2(BPW)`. The `bnd` value is computed at `log2(4096/BPW)+1` bits.
  - Set `cmd_addr ← addr_r` and `cmd_len ← chunk`.
  - If `rem_r == 0`, go to DRAIN. Otherwise go to ISSUE.
- **ISSUE:** `cmd_valid = 1`. `cmd_addr` and `cmd_len` stay stable until the handshake. On `cmd_valid & cmd_ready`:
  - `addr_r += chunk*BPW`, wrapping modulo 2^`AXI_ADDR_WIDTH`.
  - `rem_r −= chunk`.
  - `chunk_cnt++`.
  - Go to CALC.
- **DRAIN:** a guard counter runs for `DRAIN_GUARD` cycles. After it expires, the first cycle with `cmd_empty == 1` pulses `job_done` and returns to IDLE.
- **Zero-length job:** accepted, issues no commands, follows the same DRAIN path.
- **New job during DRAIN:** not accepted, because `job_ready = 0`.
- **Reset mid-job:** the job is abandoned with no partial `job_done`. Outstanding `dma_wr` commands are the integrator's concern.

## Timing
- Reset values: `cmd_valid` 0, `cmd_addr` 0, `cmd_len` 0, `job_done` 0, `busy` 0, `chunk_cnt` 0, `job_ready` 1 (state IDLE).
- Job accepted at cycle T gives first `cmd_valid` at T+2.
- Command handshake at cycle C gives next `cmd_valid` at C+2. Peak rate is one command per 2 cycles.
- Last handshake at cycle L gives `job_done` at the earliest at L+1+`DRAIN_GUARD`+1. It is later if `cmd_empty` is low.
- Zero-length job accepted at T gives `job_done` at T+2+`DRAIN_GUARD`, provided `cmd_empty` is high.
- `cmd_valid` never drops without a handshake.
- `job_done` and `job_ready` are never high in the same cycle. `job_ready` rises the cycle after `job_done`.

## Configuration
- `DMA_WR_SCHED_BOUNDARY_EN` defined: `bnd` term is included, so no command crosses a 4 KB boundary.
- Undefined: `chunk = min(rem_r, MAX_BURST)` and the `bnd` logic is not synthesized. Use this only for slaves that tolerate crossing.

## Structure
- Package `dma_pkg`: state enum `sched_state_t` (IDLE/CALC/ISSUE/DRAIN), constant `PAGE_BYTES = 4096`, and function `words_to_page(addr, bpw)`.
- Sub-module `dma_wr_chunk_calc`: combinational min/boundary computation. It is instantiated once and registered in CALC.
- The FSM, counters and the `dma_wr` connection live at top level. The `dma_wr` instance itself is not inside this block.

## Test plan
1. Job `addr=0x1000`, `len=16` → single command (0x1000, 16); `chunk_cnt=1`; `job_done` once.
2. Job `addr=0x0`, `len=600` → commands (0x0,256), (0x400,256), (0x800,88), then `job_done`.
3. Job `addr=0x0FF0`, `len=10`, 32-bit data:
   - With macro → (0xFF0,4), (0x1000,6).
   - Without macro → (0xFF0,10).
4. `cmd_ready` held low for 5 cycles during the second command of test 2 → `cmd_valid` stays high, `cmd_addr=0x400` and `cmd_len=256` stay stable, no duplicate command.
5. `len=0` with `cmd_empty=1` → no `cmd_valid`; `job_done` at T+4 with `DRAIN_GUARD=2`. With `cmd_empty` low for 10 cycles, `job_done` waits for it.
6. `rst_n` asserted during ISSUE → `cmd_valid=0` and `busy=0` immediately; after release `job_ready=1` and no `job_done`.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg: shared types and helpers for the DMA write job scheduler.
//   sched_state_t : scheduler FSM states
//   PAGE_BYTES    : AXI page size that bursts must not cross
//   words_to_page : words remaining before the next page boundary
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_t;

  localparam int unsigned PAGE_BYTES = 4096;

  // Words from a page offset up to the next 4 KB boundary; bpw is a power of two.
  function automatic logic [12:0] words_to_page(input logic [11:0] addr, input int unsigned bpw);
    logic [12:0] bytes;
    bytes = 13'(PAGE_BYTES) - {1'b0, addr};
    words_to_page = bytes;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bpw) words_to_page = bytes >> i;
    end
  endfunction

endpackage

// File: rtl/dma_wr_chunk_calc.sv
// dma_wr_chunk_calc: combinational size of the next burst command.
//   rem      : words left in the job
//   page_off : low 12 bits of the current byte address
//   chunk_c  : min(rem, MAX_BURST[, words to 4 KB boundary])
// Boundary term is present only when DMA_WR_SCHED_BOUNDARY_EN is defined.
module dma_wr_chunk_calc
  import dma_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH   = 32,
  parameter int unsigned JOB_LEN_WIDTH    = 20,
  parameter int unsigned CONFIG_LEN_WIDTH = 9,
  parameter int unsigned MAX_BURST        = 256
) (
  input  logic [JOB_LEN_WIDTH-1:0]    rem,
  input  logic [11:0]                 page_off,
  output logic [CONFIG_LEN_WIDTH-1:0] chunk_c
);

  localparam int unsigned BPW   = AXI_DATA_WIDTH / 8;
  localparam int unsigned BND_W = $clog2(PAGE_BYTES / BPW) + 1;
  localparam int unsigned CMP_W = (JOB_LEN_WIDTH > BND_W) ? JOB_LEN_WIDTH : BND_W;

  logic [CMP_W-1:0] rem_w;
  logic [CMP_W-1:0] lim_w;

`ifdef DMA_WR_SCHED_BOUNDARY_EN
  logic [BND_W-1:0] bnd_w;
  assign bnd_w = BND_W'(words_to_page(page_off, BPW));
`else
  logic [11:0] unused_page_off;
  assign unused_page_off = page_off;
`endif

  // Smallest of remaining length, burst cap and (optionally) page room.
  always_comb begin
    rem_w = CMP_W'(rem);
    lim_w = CMP_W'(MAX_BURST);
`ifdef DMA_WR_SCHED_BOUNDARY_EN
    if (CMP_W'(bnd_w) < lim_w) lim_w = CMP_W'(bnd_w);
`endif
    chunk_c = CONFIG_LEN_WIDTH'((rem_w < lim_w) ? rem_w : lim_w);
  end

endmodule

// File: rtl/dma_wr_sched.sv
// dma_wr_sched: splits one write job into burst commands for dma_wr,
// then waits for the command queue to drain and pulses job_done.
//   job_valid/job_ready/job_addr/job_len : job request (accepted in IDLE)
//   job_done                             : one-cycle completion pulse
//   busy                                 : scheduler not idle
//   cmd_valid/cmd_ready/cmd_addr/cmd_len : burst command to dma_wr config
//   cmd_empty                            : dma_wr config queue empty
//   chunk_cnt                            : commands issued for current job
// Optional: DMA_WR_SCHED_BOUNDARY_EN keeps bursts inside 4 KB pages.
module dma_wr_sched
  import dma_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH   = 32,
  parameter int unsigned AXI_ADDR_WIDTH   = 32,
  parameter int unsigned CONFIG_LEN_WIDTH = 9,
  parameter int unsigned JOB_LEN_WIDTH    = 20,
  parameter int unsigned MAX_BURST        = 256,
  parameter int unsigned DRAIN_GUARD      = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   job_addr,
  input  logic [JOB_LEN_WIDTH-1:0]    job_len,
  output logic                        job_done,
  output logic                        busy,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  output logic [CONFIG_LEN_WIDTH-1:0] cmd_len,
  input  logic                        cmd_empty,
  output logic [15:0]                 chunk_cnt
);

  localparam int unsigned BPW      = AXI_DATA_WIDTH / 8;
  localparam int unsigned BPW_LOG2 = $clog2(BPW);
  localparam int unsigned GUARD_W  = (DRAIN_GUARD > 1) ? $clog2(DRAIN_GUARD) : 1;
  // The CALC cycle is the first guard cycle, so DRAIN counts one fewer.
  localparam logic [GUARD_W-1:0] GUARD_INIT =
    GUARD_W'((DRAIN_GUARD > 0) ? DRAIN_GUARD - 1 : 0);

  sched_state_t state, state_nxt;

  logic [AXI_ADDR_WIDTH-1:0]   addr_r, addr_nxt;
  logic [JOB_LEN_WIDTH-1:0]    rem_r, rem_nxt;
  logic [CONFIG_LEN_WIDTH-1:0] chunk_r, chunk_nxt;
  logic [GUARD_W-1:0]          guard_r, guard_nxt;
  logic [CONFIG_LEN_WIDTH-1:0] chunk_c;

  logic                        job_ready_nxt, job_done_nxt, busy_nxt, cmd_valid_nxt;
  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr_nxt;
  logic [CONFIG_LEN_WIDTH-1:0] cmd_len_nxt;
  logic [15:0]                 chunk_cnt_nxt;

  dma_wr_chunk_calc #(
    .AXI_DATA_WIDTH   (AXI_DATA_WIDTH),
    .JOB_LEN_WIDTH    (JOB_LEN_WIDTH),
    .CONFIG_LEN_WIDTH (CONFIG_LEN_WIDTH),
    .MAX_BURST        (MAX_BURST)
  ) u_chunk_calc (
    .rem      (rem_r),
    .page_off (addr_r[11:0]),
    .chunk_c  (chunk_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr_r    <= '0;
      rem_r     <= '0;
      chunk_r   <= '0;
      guard_r   <= '0;
      job_ready <= 1'b1;
      job_done  <= 1'b0;
      busy      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      chunk_cnt <= '0;
    end else begin
      state     <= state_nxt;
      addr_r    <= addr_nxt;
      rem_r     <= rem_nxt;
      chunk_r   <= chunk_nxt;
      guard_r   <= guard_nxt;
      job_ready <= job_ready_nxt;
      job_done  <= job_done_nxt;
      busy      <= busy_nxt;
      cmd_valid <= cmd_valid_nxt;
      cmd_addr  <= cmd_addr_nxt;
      cmd_len   <= cmd_len_nxt;
      chunk_cnt <= chunk_cnt_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr_r;
    rem_nxt       = rem_r;
    chunk_nxt     = chunk_r;
    guard_nxt     = guard_r;
    job_done_nxt  = 1'b0;
    cmd_addr_nxt  = cmd_addr;
    cmd_len_nxt   = cmd_len;
    chunk_cnt_nxt = chunk_cnt;

    case (state)
      ST_IDLE: begin
        if (job_valid && job_ready) begin
          addr_nxt      = job_addr & ~AXI_ADDR_WIDTH'(BPW - 1);
          rem_nxt       = job_len;
          chunk_cnt_nxt = '0;
          state_nxt     = ST_CALC;
        end
      end
      ST_CALC: begin
        chunk_nxt    = chunk_c;
        cmd_addr_nxt = addr_r;
        cmd_len_nxt  = chunk_c;
        if (rem_r == '0) begin
          guard_nxt = GUARD_INIT;
          state_nxt = ST_DRAIN;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // cmd_valid is always high in ISSUE, so cmd_ready alone completes it.
        if (cmd_ready) begin
          addr_nxt = addr_r + (AXI_ADDR_WIDTH'(chunk_r) << BPW_LOG2);
          rem_nxt  = rem_r - JOB_LEN_WIDTH'(chunk_r);
          if (chunk_cnt != 16'hFFFF) chunk_cnt_nxt = chunk_cnt + 16'd1;
          state_nxt = ST_CALC;
        end
      end
      ST_DRAIN: begin
        // Hold DRAIN through the job_done cycle so job_ready never overlaps it.
        if (job_done) begin
          state_nxt = ST_IDLE;
        end else if (guard_r != '0) begin
          guard_nxt = guard_r - GUARD_W'(1);
        end else if (cmd_empty) begin
          job_done_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    job_ready_nxt = (state_nxt == ST_IDLE);
    busy_nxt      = (state_nxt != ST_IDLE);
    cmd_valid_nxt = (state_nxt == ST_ISSUE);
  end

endmodule

// File: tb/tb_dma_wr_sched.sv
// tb_dma_wr_sched: directed self-checking bench for dma_wr_sched.
// Honors DMA_WR_SCHED_BOUNDARY_EN for the page-crossing expectations.
`timescale 1ns/1ps
module tb_dma_wr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid, job_ready, job_done, busy;
  logic        cmd_valid, cmd_ready, cmd_empty;
  logic [31:0] job_addr, cmd_addr;
  logic [19:0] job_len;
  logic [8:0]  cmd_len;
  logic [15:0] chunk_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int first_v = -1;
  int t_acc = 0;

  logic [31:0] hs_addr[$];
  logic [8:0]  hs_len[$];
  int          hs_cyc[$];

  always #5 clk = ~clk;

  dma_wr_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_addr  (job_addr),
    .job_len   (job_len),
    .job_done  (job_done),
    .busy      (busy),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_empty (cmd_empty),
    .chunk_cnt (chunk_cnt)
  );

  // Edge monitor: values seen here belong to the cycle that is ending.
  always @(posedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        hs_addr.push_back(cmd_addr);
        hs_len.push_back(cmd_len);
        hs_cyc.push_back(cyc);
      end
      if (job_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cmd_valid && first_v < 0) first_v = cyc;
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_cmd(input int idx, input logic [31:0] a, input logic [8:0] l);
    if (idx < hs_addr.size()) begin
      check($sformatf("cmd%0d_addr", idx), hs_addr[idx], a);
      check($sformatf("cmd%0d_len", idx), hs_len[idx], l);
    end else begin
      check($sformatf("cmd%0d_present", idx), hs_addr.size(), idx + 1);
    end
  endtask

  task automatic start_job(input logic [31:0] a, input logic [19:0] l);
    hs_addr.delete();
    hs_len.delete();
    hs_cyc.delete();
    first_v  = -1;
    done_cyc = -1;
    @(posedge clk); #1;
    check("job_ready_idle", job_ready, 1);
    job_valid = 1'b1;
    job_addr  = a;
    job_len   = l;
    t_acc     = cyc;
    @(posedge clk); #1;
    job_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("chunk_cnt_clear", chunk_cnt, 0);
  endtask

  // Runs until job_done, optionally stalling cmd_ready on one command and
  // holding cmd_empty low until absolute cycle empty_at.
  task automatic wait_done(input int stall_idx, input int stall_len,
                           input logic [31:0] exp_a, input logic [8:0] exp_l,
                           input int empty_at);
    int left     = stall_len;
    int unstable = 0;
    bit stalling = 1'b0;
    bit got      = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk); #1;
      cmd_empty = (cyc >= empty_at);
      if (left > 0 && (stalling || (cmd_valid && hs_addr.size() == stall_idx))) begin
        stalling  = 1'b1;
        cmd_ready = 1'b0;
        left--;
        if (!cmd_valid || cmd_addr !== exp_a || cmd_len !== exp_l) unstable++;
      end else begin
        cmd_ready = 1'b1;
      end
      if (job_done) begin
        got = 1'b1;
        check("ready_low_on_done", job_ready, 0);
      end
    end
    cmd_ready = 1'b1;
    check("job_done_seen", got, 1);
    if (stall_len > 0) begin
      check("stall_unstable_cycles", unstable, 0);
      check("stall_cycles_done", stall_len - left, stall_len);
    end
    @(posedge clk); #1;
    check("ready_after_done", job_ready, 1);
    check("done_one_cycle", job_done, 0);
  endtask

  int d0;
  int last_hs;
  bit seen;

  initial begin
    rst_n = 1'b0; job_valid = 1'b0; job_addr = '0; job_len = '0;
    cmd_ready = 1'b1; cmd_empty = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_addr", cmd_addr, 0);
    check("rst_cmd_len", cmd_len, 0);
    check("rst_job_done", job_done, 0);
    check("rst_busy", busy, 0);
    check("rst_chunk_cnt", chunk_cnt, 0);
    check("rst_job_ready", job_ready, 1);
    rst_n = 1'b1;

    // Single short command.
    d0 = done_cnt;
    start_job(32'h1000, 20'd16);
    wait_done(-1, 0, 32'h0, 9'h0, 0);
    check("t1_ncmd", hs_addr.size(), 1);
    check_cmd(0, 32'h1000, 9'd16);
    check("t1_chunk_cnt", chunk_cnt, 1);
    check("t1_first_valid_lat", first_v - t_acc, 2);
    last_hs = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] : -100;
    check("t1_done_lat", done_cyc - last_hs, 4);
    check("t1_done_count", done_cnt - d0, 1);

    // Multi-burst job with a 5-cycle stall on the second command.
    d0 = done_cnt;
    start_job(32'h0, 20'd600);
    wait_done(1, 5, 32'h400, 9'd256, 0);
    check("t2_ncmd", hs_addr.size(), 3);
    check_cmd(0, 32'h000, 9'd256);
    check_cmd(1, 32'h400, 9'd256);
    check_cmd(2, 32'h800, 9'd88);
    check("t2_chunk_cnt", chunk_cnt, 3);
    check("t2_done_count", done_cnt - d0, 1);

    // Job that straddles a 4 KB page.
    start_job(32'h0FF3, 20'd10);
    wait_done(-1, 0, 32'h0, 9'h0, 0);
`ifdef DMA_WR_SCHED_BOUNDARY_EN
    check("t3_ncmd", hs_addr.size(), 2);
    check_cmd(0, 32'h0FF0, 9'd4);
    check_cmd(1, 32'h1000, 9'd6);
    check("t3_chunk_cnt", chunk_cnt, 2);
    check("t3_hs_spacing", (hs_cyc.size() > 1) ? hs_cyc[1] - hs_cyc[0] : -1, 2);
`else
    check("t3_ncmd", hs_addr.size(), 1);
    check_cmd(0, 32'h0FF0, 9'd10);
    check("t3_chunk_cnt", chunk_cnt, 1);
`endif

    // Zero-length job, queue already empty.
    start_job(32'h2000, 20'd0);
    wait_done(-1, 0, 32'h0, 9'h0, 0);
    check("t5_no_cmds", hs_addr.size(), 0);
    check("t5_no_valid", first_v, -1);
    check("t5_done_lat", done_cyc - t_acc, 4);
    check("t5_chunk_cnt", chunk_cnt, 0);

    // Zero-length job, queue empties late.
    cmd_empty = 1'b0;
    start_job(32'h2000, 20'd0);
    wait_done(-1, 0, 32'h0, 9'h0, t_acc + 10);
    check("t5b_done_lat", done_cyc - t_acc, 11);

    // Reset while a command is pending.
    cmd_ready = 1'b0;
    start_job(32'h0, 20'd600);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      seen = cmd_valid;
    end
    check("t6_valid_before_rst", cmd_valid, 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("t6_rst_cmd_valid", cmd_valid, 0);
    check("t6_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    check("t6_ready_after_rst", job_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
